// File: rtl/bch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bch_seq_pkg
// Brief    : Shared state/status encodings and default widths for the BCH
//            frame sequencer.
// Revision : 1.0
// ============================================================================
package bch_seq_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_CW_W        = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ENC  = 3'd1,
        CHAN = 3'd2,
        DEC  = 3'd3,
        RESP = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_DECFAIL = 2'b01,
        ST_TIMEOUT = 2'b10
    } seq_status_e;

    // True for the states that wait on an external stage handshake.
    function automatic logic is_stage(input seq_state_e s);
        return (s == ENC) || (s == CHAN) || (s == DEC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bch_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : bch_seq_watchdog
// Brief    : Per-stage cycle counter; flags expiry at TIMEOUT_CYC-1 cycles.
// Revision : 1.0
// ============================================================================
module bch_seq_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_BITS = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_BITS-1:0] C_LIMIT = CNT_BITS'(TIMEOUT_CYC - 1);

    logic [CNT_BITS-1:0] r_cnt;

    // Counter parks at the limit so expiry stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != C_LIMIT)) begin
            r_cnt <= r_cnt + CNT_BITS'(1);
        end
    end

    assign expired = enable && (r_cnt == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/bch_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bch_frame_sequencer
// Brief    : Schedules encoder -> noise channel -> decoder for one frame per
//            command, with per-stage watchdog and saturating statistics.
//            Optional macro BCH_SEQ_LATENCY_EN adds the last_latency output.
// Revision : 1.0
// ============================================================================
module bch_frame_sequencer
    import bch_seq_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CW_W        = DEF_CW_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_bch,
    input  logic              cmd_gauss,
    input  logic              cmd_ber,
    output logic              enc_start,
    output logic [DATA_W-1:0] enc_din,
    input  logic              enc_done,
    input  logic [CW_W-1:0]   enc_dout,
    output logic              ch_start,
    output logic [1:0]        ch_mode,
    output logic [CW_W-1:0]   ch_din,
    input  logic              ch_done,
    input  logic [CW_W-1:0]   ch_dout,
    output logic              dec_start,
    output logic [CW_W-1:0]   dec_din,
    input  logic              dec_done,
    input  logic [DATA_W-1:0] dec_dout,
    input  logic              dec_fail,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  fail_cnt
`ifdef BCH_SEQ_LATENCY_EN
    ,
    output logic [CNT_W-1:0]  last_latency
`endif
);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic              r_entry;
    logic [DATA_W-1:0] r_data;
    logic [CW_W-1:0]   r_word;
    logic [CW_W-1:0]   w_word_nxt;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] w_result_nxt;
    seq_status_e       r_status;
    seq_status_e       w_status_nxt;
    logic              r_bch;
    logic              r_gauss;
    logic              r_ber;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;

    logic w_accept;
    logic w_rsp_hs;
    logic w_noise;
    logic w_state_chg;
    logic w_wd_en;
    logic w_wd_expired;

    assign w_accept    = (r_state == IDLE) && cmd_valid;
    assign w_rsp_hs    = (r_state == RESP) && rsp_ready;
    assign w_noise     = r_gauss || r_ber;
    assign w_state_chg = (w_state_nxt != r_state);
    assign w_wd_en     = is_stage(r_state);

    bch_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_state_chg),
        .enable  (w_wd_en),
        .expired (w_wd_expired)
    );

    // Next-state and datapath updates; a stage's done always beats its timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_word_nxt   = r_word;
        w_result_nxt = r_result;
        w_status_nxt = r_status;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_word_nxt = CW_W'(cmd_data);
                    if (cmd_bch) begin
                        w_state_nxt = ENC;
                    end else if (cmd_gauss || cmd_ber) begin
                        w_state_nxt = CHAN;
                    end else begin
                        w_state_nxt  = RESP;
                        w_result_nxt = cmd_data;
                        w_status_nxt = ST_OK;
                    end
                end
            end
            ENC: begin
                if (enc_done) begin
                    w_word_nxt  = enc_dout;
                    w_state_nxt = w_noise ? CHAN : DEC;
                end else if (w_wd_expired) begin
                    w_state_nxt  = RESP;
                    w_result_nxt = '0;
                    w_status_nxt = ST_TIMEOUT;
                end
            end
            CHAN: begin
                if (ch_done) begin
                    w_word_nxt = ch_dout;
                    if (r_bch) begin
                        w_state_nxt = DEC;
                    end else begin
                        w_state_nxt  = RESP;
                        w_result_nxt = ch_dout[DATA_W-1:0];
                        w_status_nxt = ST_OK;
                    end
                end else if (w_wd_expired) begin
                    w_state_nxt  = RESP;
                    w_result_nxt = '0;
                    w_status_nxt = ST_TIMEOUT;
                end
            end
            DEC: begin
                if (dec_done) begin
                    w_state_nxt  = RESP;
                    w_result_nxt = dec_dout;
                    w_status_nxt = dec_fail ? ST_DECFAIL : ST_OK;
                end else if (w_wd_expired) begin
                    w_state_nxt  = RESP;
                    w_result_nxt = '0;
                    w_status_nxt = ST_TIMEOUT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_entry     <= 1'b0;
            r_data      <= '0;
            r_word      <= '0;
            r_result    <= '0;
            r_status    <= ST_OK;
            r_bch       <= 1'b0;
            r_gauss     <= 1'b0;
            r_ber       <= 1'b0;
            r_frame_cnt <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_entry  <= w_state_chg;
            r_word   <= w_word_nxt;
            r_result <= w_result_nxt;
            r_status <= w_status_nxt;
            if (w_accept) begin
                r_data  <= cmd_data;
                r_bch   <= cmd_bch;
                r_gauss <= cmd_gauss;
                r_ber   <= cmd_ber;
            end
            if (w_rsp_hs) begin
                if (r_frame_cnt != {CNT_W{1'b1}}) begin
                    r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                end
                if ((r_status != ST_OK) && (r_fail_cnt != {CNT_W{1'b1}})) begin
                    r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef BCH_SEQ_LATENCY_EN
    logic [CNT_W-1:0] r_lat_run;
    logic [CNT_W-1:0] r_last_latency;

    // r_lat_run holds cycles elapsed since accept as seen in the current cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_run      <= '0;
            r_last_latency <= '0;
        end else begin
            if (w_accept) begin
                r_lat_run <= CNT_W'(1);
            end else if (is_stage(r_state) && (r_lat_run != {CNT_W{1'b1}})) begin
                r_lat_run <= r_lat_run + CNT_W'(1);
            end
            if ((w_state_nxt == RESP) && (r_state != RESP)) begin
                if (r_state == IDLE) begin
                    r_last_latency <= CNT_W'(1);
                end else if (r_lat_run != {CNT_W{1'b1}}) begin
                    r_last_latency <= r_lat_run + CNT_W'(1);
                end else begin
                    r_last_latency <= r_lat_run;
                end
            end
        end
    end

    assign last_latency = r_last_latency;
`endif

    assign cmd_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign enc_start  = (r_state == ENC)  && r_entry;
    assign ch_start   = (r_state == CHAN) && r_entry;
    assign dec_start  = (r_state == DEC)  && r_entry;
    assign enc_din    = r_data;
    assign ch_mode    = {r_ber, r_gauss};
    assign ch_din     = r_word;
    assign dec_din    = r_word;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_data   = r_result;
    assign rsp_status = r_status;
    assign frame_cnt  = r_frame_cnt;
    assign fail_cnt   = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bch_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_frame_sequencer
// Brief    : Directed scoreboard bench for bch_frame_sequencer with behavioural
//            encoder/channel/decoder responders.
// Revision : 1.0
// ============================================================================
module tb_bch_frame_sequencer;

    localparam int DATA_W      = 8;
    localparam int CW_W        = 16;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              cmd_bch = 1'b0;
    logic              cmd_gauss = 1'b0;
    logic              cmd_ber = 1'b0;
    logic              enc_start;
    logic [DATA_W-1:0] enc_din;
    logic              enc_done = 1'b0;
    logic [CW_W-1:0]   enc_dout = '0;
    logic              ch_start;
    logic [1:0]        ch_mode;
    logic [CW_W-1:0]   ch_din;
    logic              ch_done = 1'b0;
    logic [CW_W-1:0]   ch_dout = '0;
    logic              dec_start;
    logic [CW_W-1:0]   dec_din;
    logic              dec_done = 1'b0;
    logic [DATA_W-1:0] dec_dout = '0;
    logic              dec_fail = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_status;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  fail_cnt;

    always #5 clk = ~clk;

    bch_frame_sequencer #(
        .DATA_W      (DATA_W),
        .CW_W        (CW_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_bch    (cmd_bch),
        .cmd_gauss  (cmd_gauss),
        .cmd_ber    (cmd_ber),
        .enc_start  (enc_start),
        .enc_din    (enc_din),
        .enc_done   (enc_done),
        .enc_dout   (enc_dout),
        .ch_start   (ch_start),
        .ch_mode    (ch_mode),
        .ch_din     (ch_din),
        .ch_done    (ch_done),
        .ch_dout    (ch_dout),
        .dec_start  (dec_start),
        .dec_din    (dec_din),
        .dec_done   (dec_done),
        .dec_dout   (dec_dout),
        .dec_fail   (dec_fail),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .fail_cnt   (fail_cnt)
    );

    int checks   = 0;
    int failures = 0;
    logic [DATA_W+1:0] sb_q[$];

    // Responder configuration, set by the stimulus before each frame.
    int              enc_lat = 1, ch_lat = 1, dec_lat = 1;
    logic            enc_hang = 1'b0, dec_hang = 1'b0;
    logic [CW_W-1:0] enc_val = '0, ch_val = '0;
    logic [7:0]      dec_val = '0;
    logic            dec_fail_v = 1'b0;
    logic [1:0]      ch_mode_exp = 2'b00;
    logic [7:0]      enc_din_seen = '0;
    logic [CW_W-1:0] ch_din_seen = '0, dec_din_seen = '0;
    int              ch_mode_errs = 0;
    int              n_enc = 0, n_ch = 0, n_dec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (enc_start) n_enc++;
        if (ch_start)  n_ch++;
        if (dec_start) n_dec++;
    end

    // Stage models: done arrives N cycles after the start cycle.
    always begin
        @(negedge clk);
        if (!rst && enc_start) begin
            enc_din_seen = enc_din;
            if (!enc_hang) begin
                repeat (enc_lat) @(negedge clk);
                enc_dout = enc_val;
                enc_done = 1'b1;
                @(negedge clk);
                enc_done = 1'b0;
            end
        end
    end

    always begin
        @(negedge clk);
        if (!rst && ch_start) begin
            ch_din_seen = ch_din;
            for (int i = 0; i < ch_lat; i++) begin
                if (ch_mode !== ch_mode_exp) ch_mode_errs++;
                @(negedge clk);
            end
            if (ch_mode !== ch_mode_exp) ch_mode_errs++;
            ch_dout = ch_val;
            ch_done = 1'b1;
            @(negedge clk);
            ch_done = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        if (!rst && dec_start) begin
            dec_din_seen = dec_din;
            if (!dec_hang) begin
                repeat (dec_lat) @(negedge clk);
                dec_dout = dec_val;
                dec_fail = dec_fail_v;
                dec_done = 1'b1;
                @(negedge clk);
                dec_done = 1'b0;
                dec_fail = 1'b0;
            end
        end
    end

    // Scoreboard monitor: one compare per response handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", {22'd0, rsp_data, rsp_status}, 32'hFFFF_FFFF);
            end else begin
                chk("rsp_data_status", {22'd0, rsp_data, rsp_status}, {22'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic b, input logic g, input logic r,
                        input logic [DATA_W+1:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmd_data  = d;
        cmd_bch   = b;
        cmd_gauss = g;
        cmd_ber   = r;
        cmd_valid = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Returns the number of cycles after the first post-accept cycle until rsp_valid.
    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp_arrives", {31'd0, rsp_valid}, 32'd1);
        if (rsp_valid && rsp_ready) @(negedge clk);
    endtask

    initial begin
        int cyc, e0, c0, d0, m0, n, bad;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("reset_fail_cnt", {24'd0, fail_cnt}, 32'd0);
        chk("reset_starts", {29'd0, enc_start, ch_start, dec_start}, 32'd0);
        rst = 1'b0;

        // Frame 1: encode + decode, channel skipped.
        enc_lat = 3; enc_val = 16'h01A5; dec_lat = 4; dec_val = 8'hA5; dec_fail_v = 1'b0;
        e0 = n_enc; c0 = n_ch; d0 = n_dec;
        send(8'hA5, 1'b1, 1'b0, 1'b0, {8'hA5, 2'b00});
        wait_rsp(cyc);
        chk("t1_latency", cyc + 1, 10);
        chk("t1_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        chk("t1_enc_pulses", n_enc - e0, 1);
        chk("t1_ch_pulses", n_ch - c0, 0);
        chk("t1_dec_pulses", n_dec - d0, 1);
        chk("t1_enc_din", {24'd0, enc_din_seen}, 32'hA5);
        chk("t1_dec_din", {16'd0, dec_din_seen}, 32'h01A5);

        // Frame 2: full chain with Gaussian noise, decoder reports failure.
        enc_lat = 2; enc_val = 16'h115A; ch_lat = 2; ch_val = 16'h915A; ch_mode_exp = 2'b01;
        dec_lat = 1; dec_val = 8'h77; dec_fail_v = 1'b1;
        m0 = ch_mode_errs;
        send(8'h5A, 1'b1, 1'b1, 1'b0, {8'h77, 2'b01});
        wait_rsp(cyc);
        chk("t2_latency", cyc + 1, 9);
        chk("t2_fail_cnt", {24'd0, fail_cnt}, 32'd1);
        chk("t2_frame_cnt", {24'd0, frame_cnt}, 32'd2);
        chk("t2_ch_mode_held", ch_mode_errs - m0, 0);
        chk("t2_ch_din", {16'd0, ch_din_seen}, 32'h115A);
        chk("t2_dec_din", {16'd0, dec_din_seen}, 32'h915A);

        // Frame 3: full bypass.
        e0 = n_enc; c0 = n_ch; d0 = n_dec;
        send(8'h3C, 1'b0, 1'b0, 1'b0, {8'h3C, 2'b00});
        wait_rsp(cyc);
        chk("t3_latency", cyc + 1, 1);
        chk("t3_no_starts", (n_enc - e0) + (n_ch - c0) + (n_dec - d0), 0);

        // Frame 4: BER channel only, result is low byte of corrupted word.
        ch_lat = 1; ch_val = 16'hBE42; ch_mode_exp = 2'b10;
        m0 = ch_mode_errs;
        send(8'h81, 1'b0, 1'b0, 1'b1, {8'h42, 2'b00});
        wait_rsp(cyc);
        chk("t4_latency", cyc + 1, 3);
        chk("t4_ch_din", {16'd0, ch_din_seen}, 32'h0081);
        chk("t4_ch_mode_held", ch_mode_errs - m0, 0);
        chk("t4_fail_cnt", {24'd0, fail_cnt}, 32'd1);

        // Frame 5: encoder hangs, watchdog aborts.
        enc_hang = 1'b1;
        send(8'h99, 1'b1, 1'b0, 1'b0, {8'h00, 2'b10});
        wait_rsp(cyc);
        chk("t5_timeout_cycles", cyc, TIMEOUT_CYC);
        chk("t5_fail_cnt", {24'd0, fail_cnt}, 32'd2);
        enc_hang = 1'b0;

        // Frame 6: done lands on the expiry cycle and must win.
        enc_lat = TIMEOUT_CYC - 1; enc_val = 16'h00E7; dec_lat = 1; dec_val = 8'hE7; dec_fail_v = 1'b0;
        send(8'hE7, 1'b1, 1'b0, 1'b0, {8'hE7, 2'b00});
        wait_rsp(cyc);
        chk("t6_done_beats_timeout", {24'd0, fail_cnt}, 32'd2);

        // Frame 7: consumer stalls for 10 cycles.
        rsp_ready = 1'b0;
        send(8'hC3, 1'b0, 1'b0, 1'b0, {8'hC3, 2'b00});
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_data !== 8'hC3 || rsp_status !== 2'b00 || cmd_ready) bad++;
            @(negedge clk);
        end
        chk("t7_hold_stable", bad, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t7_frame_cnt", {24'd0, frame_cnt}, 32'd7);
        chk("t7_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

        // Frame 8: reset while the decoder is working.
        enc_lat = 1; enc_val = 16'h0011; dec_hang = 1'b1;
        d0 = n_dec;
        send(8'h11, 1'b1, 1'b0, 1'b0, {8'h11, 2'b00});
        n = 0;
        while (n_dec == d0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t8_reached_dec", n_dec - d0, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb_q.delete();
        chk("t8_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t8_rst_busy", {31'd0, busy}, 32'd0);
        chk("t8_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t8_rst_counters", {16'd0, frame_cnt, fail_cnt}, 32'd0);
        rst = 1'b0;
        dec_hang = 1'b0;

        // Counter saturation: more than 2^CNT_W bypass frames.
        for (int i = 0; i < 260; i++) begin
            logic [7:0] d;
            d = 8'(i);
            send(d, 1'b0, 1'b0, 1'b0, {d, 2'b00});
            wait_rsp(cyc);
        end
        chk("sat_frame_cnt", {24'd0, frame_cnt}, 32'hFF);
        chk("sat_fail_cnt", {24'd0, fail_cnt}, 32'd0);

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/bch_frame_sequencer.md
Name: bch_frame_sequencer

Overview:
- Per-frame scheduler for the BCH test datapath: encoder -> noise channel (Gauss/BER) -> decoder.
- Accepts one command (data byte plus mode bits) from the AXI-lite register front end.
- Runs each enabled stage in order using start/done handshakes, with a per-stage watchdog.
- Returns the decoded byte and a status code; keeps frame and failure statistics for software.

Parameters:
- DATA_W, 8, width of the user data byte.
- CW_W, 16, codeword width carried between stages (data zero-extended when bypassed).
- TIMEOUT_CYC, 1024, maximum cycles a stage may take before abort.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_data  in  DATA_W  frame payload
- cmd_bch  in  1  enable encode and decode stages
- cmd_gauss  in  1  enable Gaussian noise in the channel stage
- cmd_ber  in  1  enable BER-generator noise in the channel stage
- enc_start  out  1  one-cycle start pulse to the encoder
- enc_din  out  DATA_W  encoder input
- enc_done  in  1  encoder result valid (one-cycle pulse)
- enc_dout  in  CW_W  encoder codeword
- ch_start  out  1  one-cycle start pulse to the channel
- ch_mode  out  2  {ber, gauss} for the channel
- ch_din  out  CW_W  channel input
- ch_done  in  1  channel result valid
- ch_dout  in  CW_W  corrupted word
- dec_start  out  1  one-cycle start pulse to the decoder
- dec_din  out  CW_W  decoder input
- dec_done  in  1  decoder result valid
- dec_dout  in  DATA_W  decoded byte
- dec_fail  in  1  uncorrectable error flag, sampled with dec_done
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_data  out  DATA_W  final byte
- rsp_status  out  2  00 OK, 01 decode fail, 10 timeout
- busy  out  1  state is not IDLE
- frame_cnt  out  CNT_W  completed frames
- fail_cnt  out  CNT_W  frames with status other than OK

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1; internal state IDLE; counters 0.
- Reset mid-frame aborts immediately; no response is produced for that frame.
- State machine: IDLE, ENC, CHAN, DEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch data and mode bits; word_q = zero-extended cmd_data.
  - Next state is the first enabled stage: ENC if bch, else CHAN if (gauss|ber), else RESP.
- Start pulses:
  - The stage start output is asserted for exactly the first cycle of the state.
  - enc_din, ch_din, dec_din and ch_mode are driven from registers and held stable for the whole state.
- ENC: on enc_done, word_q = enc_dout; next state is CHAN if noise enabled, else DEC.
- CHAN: on ch_done, word_q = ch_dout; next state is DEC if bch, else RESP.
- DEC: on dec_done, result = dec_dout and status = dec_fail ? 01 : 00; go to RESP.
- Bypass: if bch=0, result = word_q[DATA_W-1:0] on entering RESP, status 00.
- Watchdog:
  - Counts cycles in ENC, CHAN and DEC; cleared on every state change.
  - If it reaches TIMEOUT_CYC-1 without done: status 10, result 0, go to RESP.
  - If done arrives in that same cycle, done wins.
- RESP:
  - rsp_valid=1; rsp_data and rsp_status are stable until rsp_ready.
  - On handshake: frame_cnt++; fail_cnt++ if status is not 00; return to IDLE (cmd_ready high the next cycle).
  - Counters saturate at all-ones; no wrap.
- Latency with zero-cycle stages:
  - Minimum command-to-rsp_valid is 1 cycle in full bypass.
  - Otherwise it is the sum of the enabled stage latencies plus 1 cycle per stage transition.
- A done pulse arriving in a state that does not expect it is ignored.

Optional Feature:
- Macro: BCH_SEQ_LATENCY_EN.
- When defined: extra output last_latency [CNT_W] holds the cycles from command accept to rsp_valid for the last frame. It updates on entry to RESP and resets to 0.
- When not defined: the port and its counter are absent.

Decomposition:
- Package bch_seq_pkg holds:
  - state enum seq_state_e (IDLE, ENC, CHAN, DEC, RESP);
  - status enum (ST_OK=2'b00, ST_DECFAIL=2'b01, ST_TIMEOUT=2'b10);
  - default widths.
- Sub-module bch_seq_watchdog (inputs clear, enable; output expired; parameter TIMEOUT_CYC) is the one natural split.

Test Plan:
- bch=1, gauss=0, ber=0, data 0xA5; encoder returns 0x1A5 after 3 cycles; decoder returns 0xA5 after 4 cycles with fail=0 -> CHAN skipped, rsp_data=0xA5, status 00, frame_cnt=1.
- bch=1, gauss=1; decoder asserts dec_fail -> status 01, fail_cnt=1; ch_mode=01 held throughout CHAN.
- bch=0, gauss=0, ber=0, data 0x3C -> rsp_valid one cycle after accept, rsp_data=0x3C, and no start pulses issued.
- Encoder never returns done, TIMEOUT_CYC=16 -> status 10 exactly 16 cycles after enc_start, rsp_data=0x00.
- rsp_ready held low for 10 cycles -> rsp_valid/data stable and cmd_ready=0 throughout; rst asserted during DEC -> next cycle IDLE, cmd_ready=1, counters 0.
- 65536 frames with CNT_W=16 -> frame_cnt saturates at 0xFFFF.
